// File: rtl/periph_arb_pkg.sv
// Shared types and defaults for the peripheral TX round-robin arbiter.
package periph_arb_pkg;

    typedef enum logic [0:0] {
        IDLE,
        GRANT
    } arb_state_t;

    localparam int unsigned NUM_PERIPHS_DEFAULT = 8;
    localparam int unsigned BURST_MAX_DEFAULT   = 16;

    function automatic int unsigned periph_id_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned PERIPH_ID_W = periph_id_w(NUM_PERIPHS_DEFAULT);

endpackage

// File: rtl/periph_tx_arbiter_if.sv
// FIFO-side and controller-side signals of the peripheral TX arbiter.
interface periph_tx_arbiter_if
    import periph_arb_pkg::*;
#(
    parameter int unsigned NUM_PERIPHS = NUM_PERIPHS_DEFAULT,
    parameter int unsigned DATA_WIDTH  = 32
);
    localparam int unsigned ID_W = periph_id_w(NUM_PERIPHS);

    logic                              periph_ready;
    logic [NUM_PERIPHS-1:0]            periph_enable;
    logic [NUM_PERIPHS-1:0]            periph_empty;
    logic [NUM_PERIPHS*DATA_WIDTH-1:0] periph_data;
    logic [NUM_PERIPHS-1:0]            periph_rd_en;
    logic                              data_available;
    logic                              read_data;
    logic [DATA_WIDTH-1:0]             data_out;
    logic [ID_W-1:0]                   grant_id;
    logic                              grant_active;

    // Arbiter side.
    modport master (
        input  periph_ready, periph_enable, periph_empty, periph_data, read_data,
        output periph_rd_en, data_available, data_out, grant_id, grant_active
    );

    // FIFO / controller side.
    modport slave (
        output periph_ready, periph_enable, periph_empty, periph_data, read_data,
        input  periph_rd_en, data_available, data_out, grant_id, grant_active
    );

endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request at or after last_id+1, with wrap.
module rr_picker
    import periph_arb_pkg::*;
#(
    parameter int unsigned NUM_PERIPHS = NUM_PERIPHS_DEFAULT,
    localparam int unsigned IdW = periph_id_w(NUM_PERIPHS)
) (
    input  logic [NUM_PERIPHS-1:0] req,
    input  logic [IdW-1:0]         last_id,
    output logic                   valid,
    output logic [IdW-1:0]         pick_id
);

    logic [2*NUM_PERIPHS-2:0] dbl;
    logic [NUM_PERIPHS-1:0]   rot;
    logic [IdW:0]             start;
    logic [IdW:0]             idx;
    logic [IdW:0]             sum;
    logic                     found;

    always_comb begin
        // The top copy only needs N-1 bits: a rotation never reaches past start+N-1.
        dbl   = {req[NUM_PERIPHS-2:0], req};
        start = (last_id == IdW'(NUM_PERIPHS - 1)) ? '0 : ({1'b0, last_id} + 1'b1);
        rot   = '0;
        idx   = '0;
        for (int i = 0; i < int'(NUM_PERIPHS); i++) begin
            idx    = start + (IdW + 1)'(i);
            rot[i] = dbl[idx];
        end

        valid   = |req;
        pick_id = '0;
        found   = 1'b0;
        sum     = '0;
        for (int i = 0; i < int'(NUM_PERIPHS); i++) begin
            if (!found && rot[i]) begin
                found = 1'b1;
                sum   = start + (IdW + 1)'(i);
                if (sum >= (IdW + 1)'(NUM_PERIPHS)) begin
                    sum = sum - (IdW + 1)'(NUM_PERIPHS);
                end
                pick_id = sum[IdW-1:0];
            end
        end
    end

endmodule

// File: rtl/periph_tx_arbiter.sv
// Round-robin arbiter sharing the FT601 write path among peripheral FWFT TX FIFOs,
// with bursts bounded by BURST_MAX.
module periph_tx_arbiter
    import periph_arb_pkg::*;
#(
    parameter int unsigned NUM_PERIPHS = NUM_PERIPHS_DEFAULT,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned BURST_MAX   = BURST_MAX_DEFAULT
) (
    input logic               clk,
    input logic               rst,
    periph_tx_arbiter_if.master bus
);

    localparam int unsigned IdW  = periph_id_w(NUM_PERIPHS);
    localparam int unsigned CntW = $clog2(BURST_MAX + 1);

    arb_state_t             state_q;
    logic [IdW-1:0]         grant_id_q;
    logic [IdW-1:0]         last_id_q;
    logic [CntW-1:0]        burst_cnt_q;

    logic [NUM_PERIPHS-1:0] req;
    logic                   pick_valid;
    logic [IdW-1:0]         pick_id;
    logic                   head_valid;
    logic                   pop;
    logic                   burst_done;
    logic                   exit_grant;

    rr_picker #(
        .NUM_PERIPHS(NUM_PERIPHS)
    ) u_picker (
        .req     (req),
        .last_id (last_id_q),
        .valid   (pick_valid),
        .pick_id (pick_id)
    );

    always_comb begin
        req        = ~bus.periph_empty & bus.periph_enable;
        head_valid = (state_q == GRANT) && !bus.periph_empty[grant_id_q];
        // A grant being torn down by reset must not pop a word that nobody will forward.
        pop        = head_valid && bus.read_data && !rst;
        burst_done = pop && (burst_cnt_q == CntW'(BURST_MAX - 1));
        exit_grant = burst_done || bus.periph_empty[grant_id_q] || !bus.periph_ready ||
                     !bus.periph_enable[grant_id_q];
    end

    assign bus.periph_rd_en   = pop ? (NUM_PERIPHS'(1) << grant_id_q) : '0;
    assign bus.data_available = head_valid;
    assign bus.data_out       = bus.periph_data[grant_id_q*DATA_WIDTH +: DATA_WIDTH];
    assign bus.grant_id       = grant_id_q;
    assign bus.grant_active   = (state_q == GRANT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            grant_id_q  <= '0;
            last_id_q   <= IdW'(NUM_PERIPHS - 1);
            burst_cnt_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.periph_ready && pick_valid) begin
                        grant_id_q  <= pick_id;
                        last_id_q   <= pick_id;
                        burst_cnt_q <= '0;
                        state_q     <= GRANT;
                    end
                end
                GRANT: begin
                    if (pop) begin
                        burst_cnt_q <= burst_cnt_q + 1'b1;
                    end
                    if (exit_grant) begin
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_periph_tx_arbiter.sv
// Directed bench for periph_tx_arbiter with a behavioural FWFT FIFO model per port.
module tb_periph_tx_arbiter;
    import periph_arb_pkg::*;

    localparam int N  = 8;
    localparam int DW = 32;
    localparam int BM = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    periph_tx_arbiter_if #(.NUM_PERIPHS(N), .DATA_WIDTH(DW)) bus ();

    periph_tx_arbiter #(
        .NUM_PERIPHS(N),
        .DATA_WIDTH (DW),
        .BURST_MAX  (BM)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int vectors = 0;
    int miscompares = 0;
    int cnt[N];
    int popped[N];
    int grants_q[$];
    int bursts_q[$];
    int gaps_q[$];
    logic prev_ga = 1'b0;
    int cur_burst = 0;
    int idle_run = 0;

    // Head word of port i: port number in the top byte, sequence number below.
    function automatic logic [31:0] head(input int i);
        int p;
        p = popped[i];
        return {i[7:0], p[23:0]};
    endfunction

    function automatic int total();
        int s = 0;
        for (int i = 0; i < N; i++) s += cnt[i];
        return s;
    endfunction

    task automatic drive_fifos();
        for (int i = 0; i < N; i++) begin
            bus.periph_empty[i] = (cnt[i] == 0);
            bus.periph_data[i*DW +: DW] = head(i);
        end
    endtask

    // One clock: sample and log before the edge, then apply pops to the FIFO model.
    task automatic step();
        logic [N-1:0] rd;
        #1;
        vectors++;
        if (!$onehot0(bus.periph_rd_en)) begin
            miscompares++;
            $display("FAIL rd_en_onehot: got %b, need at most one bit", bus.periph_rd_en);
        end
        rd = bus.periph_rd_en;
        if (bus.grant_active && !prev_ga) begin
            grants_q.push_back(int'(bus.grant_id));
            gaps_q.push_back(idle_run);
            cur_burst = 0;
        end
        if (!bus.grant_active && prev_ga) bursts_q.push_back(cur_burst);
        for (int i = 0; i < N; i++) begin
            if (rd[i]) begin
                cur_burst++;
                vectors++;
                if (bus.data_out !== head(i)) begin
                    miscompares++;
                    $display("FAIL pop_data port %0d: got %h, need %h", i, bus.data_out, head(i));
                end
            end
        end
        idle_run = bus.grant_active ? 0 : idle_run + 1;
        prev_ga = bus.grant_active;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (rd[i]) begin
                cnt[i]--;
                popped[i]++;
            end
        end
        drive_fifos();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < N; i++) begin
            cnt[i] = 0;
            popped[i] = 0;
        end
        drive_fifos();
        step();
        step();
        rst = 1'b0;
        grants_q.delete();
        bursts_q.delete();
        gaps_q.delete();
        prev_ga = 1'b0;
        idle_run = 0;
        cur_burst = 0;
    endtask

    task automatic drain();
        int k;
        for (k = 0; k < 600; k++) begin
            if (!bus.grant_active && !prev_ga && total() == 0) break;
            step();
        end
        vectors++;
        if (k >= 600) begin
            miscompares++;
            $display("FAIL drain_timeout: got %0d words left, need 0", total());
        end
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        vectors += 7;
        if (bus.grant_active !== 1'b0) begin miscompares++; $display("FAIL rst_grant_active: got %b, need 0", bus.grant_active); end
        if (bus.data_available !== 1'b0) begin miscompares++; $display("FAIL rst_data_available: got %b, need 0", bus.data_available); end
        if (bus.periph_rd_en !== 8'h00) begin miscompares++; $display("FAIL rst_rd_en: got %h, need 00", bus.periph_rd_en); end
        if (bus.grant_id !== 3'd0) begin miscompares++; $display("FAIL rst_grant_id: got %0d, need 0", bus.grant_id); end
        if (dut.last_id_q !== 3'd7) begin miscompares++; $display("FAIL rst_last_id: got %0d, need 7", dut.last_id_q); end
        if (dut.burst_cnt_q !== 5'd0) begin miscompares++; $display("FAIL rst_burst_cnt: got %0d, need 0", dut.burst_cnt_q); end
        if (dut.state_q !== IDLE) begin miscompares++; $display("FAIL rst_state: got %0d, need IDLE", dut.state_q); end
    endtask

    task automatic test_two_ports();
        do_reset();
        bus.read_data = 1'b1;
        cnt[2] = 3;
        cnt[5] = 3;
        drive_fifos();
        #1;
        vectors++;
        if (bus.grant_active !== 1'b0) begin miscompares++; $display("FAIL latency_early: got %b, need 0", bus.grant_active); end
        step();
        #1;
        vectors += 4;
        if (bus.grant_active !== 1'b1) begin miscompares++; $display("FAIL latency_grant: got %b, need 1", bus.grant_active); end
        if (bus.data_available !== 1'b1) begin miscompares++; $display("FAIL latency_avail: got %b, need 1", bus.data_available); end
        if (bus.grant_id !== 3'd2) begin miscompares++; $display("FAIL first_grant_id: got %0d, need 2", bus.grant_id); end
        if (bus.data_out !== 32'h0200_0000) begin miscompares++; $display("FAIL first_word: got %h, need 02000000", bus.data_out); end
        drain();
        vectors++;
        if (grants_q.size() != 2 || bursts_q.size() != 2 || gaps_q.size() != 2) begin
            miscompares++;
            $display("FAIL two_port_count: got %0d grants, need 2", grants_q.size());
        end else begin
            vectors += 5;
            if (grants_q[0] != 2) begin miscompares++; $display("FAIL two_port_g0: got %0d, need 2", grants_q[0]); end
            if (grants_q[1] != 5) begin miscompares++; $display("FAIL two_port_g1: got %0d, need 5", grants_q[1]); end
            if (bursts_q[0] != 3) begin miscompares++; $display("FAIL two_port_b0: got %0d, need 3", bursts_q[0]); end
            if (bursts_q[1] != 3) begin miscompares++; $display("FAIL two_port_b1: got %0d, need 3", bursts_q[1]); end
            if (gaps_q[1] != 1) begin miscompares++; $display("FAIL two_port_gap: got %0d, need 1", gaps_q[1]); end
        end
    endtask

    task automatic test_burst_limit();
        int exp_g[4] = '{3, 4, 3, 3};
        int exp_b[4] = '{16, 1, 16, 8};
        do_reset();
        bus.read_data = 1'b1;
        cnt[3] = 40;
        cnt[4] = 1;
        drive_fifos();
        drain();
        vectors++;
        if (grants_q.size() != 4 || bursts_q.size() != 4) begin
            miscompares++;
            $display("FAIL burst_count: got %0d grants %0d bursts, need 4 4", grants_q.size(), bursts_q.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                vectors += 2;
                if (grants_q[k] != exp_g[k]) begin miscompares++; $display("FAIL burst_grant[%0d]: got %0d, need %0d", k, grants_q[k], exp_g[k]); end
                if (bursts_q[k] != exp_b[k]) begin miscompares++; $display("FAIL burst_len[%0d]: got %0d, need %0d", k, bursts_q[k], exp_b[k]); end
            end
            for (int k = 1; k < 4; k++) begin
                vectors++;
                if (gaps_q[k] != 1) begin miscompares++; $display("FAIL burst_gap[%0d]: got %0d, need 1", k, gaps_q[k]); end
            end
        end
    endtask

    task automatic test_all_busy();
        do_reset();
        bus.read_data = 1'b1;
        for (int i = 0; i < N; i++) cnt[i] = 1000;
        drive_fifos();
        for (int k = 0; k < 200; k++) step();
        vectors++;
        if (grants_q.size() < 9) begin
            miscompares++;
            $display("FAIL busy_grants: got %0d, need at least 9", grants_q.size());
        end
        for (int k = 0; k < grants_q.size(); k++) begin
            vectors++;
            if (grants_q[k] != k % N) begin miscompares++; $display("FAIL busy_order[%0d]: got %0d, need %0d", k, grants_q[k], k % N); end
            if (k > 0) begin
                vectors += 2;
                if (gaps_q[k] != 1) begin miscompares++; $display("FAIL busy_gap[%0d]: got %0d, need 1", k, gaps_q[k]); end
                if (grants_q[k] == grants_q[k-1]) begin miscompares++; $display("FAIL busy_repeat[%0d]: got %0d twice, need different", k, grants_q[k]); end
            end
        end
        for (int k = 0; k < bursts_q.size(); k++) begin
            vectors++;
            if (bursts_q[k] != BM) begin miscompares++; $display("FAIL busy_len[%0d]: got %0d, need %0d", k, bursts_q[k], BM); end
        end
        for (int i = 0; i < N; i++) cnt[i] = 0;
        drive_fifos();
        drain();
    endtask

    task automatic test_read_toggle();
        do_reset();
        bus.read_data = 1'b0;
        cnt[1] = 4;
        drive_fifos();
        step();
        vectors++;
        if (bus.grant_active !== 1'b1) begin miscompares++; $display("FAIL toggle_grant: got %b, need 1", bus.grant_active); end
        for (int k = 0; k < 8; k++) begin
            bus.read_data = (k % 2 == 0);
            #1;
            vectors++;
            if (k % 2 == 0 && k < 8) begin
                if (bus.periph_rd_en !== 8'h02) begin miscompares++; $display("FAIL toggle_rd[%0d]: got %h, need 02", k, bus.periph_rd_en); end
                vectors++;
                if (bus.data_out !== 32'h0100_0000 + k / 2) begin miscompares++; $display("FAIL toggle_data[%0d]: got %h, need %h", k, bus.data_out, 32'h0100_0000 + k / 2); end
            end else if (bus.periph_rd_en !== 8'h00) begin
                miscompares++;
                $display("FAIL toggle_rd[%0d]: got %h, need 00", k, bus.periph_rd_en);
            end
            step();
        end
        vectors += 3;
        if (bus.grant_active !== 1'b0) begin miscompares++; $display("FAIL toggle_exit: got %b, need 0", bus.grant_active); end
        if (dut.burst_cnt_q !== 5'd4) begin miscompares++; $display("FAIL toggle_cnt: got %0d, need 4", dut.burst_cnt_q); end
        if (popped[1] != 4) begin miscompares++; $display("FAIL toggle_pops: got %0d, need 4", popped[1]); end
        bus.read_data = 1'b1;
        drain();
    endtask

    task automatic test_enable_mask();
        do_reset();
        bus.read_data = 1'b1;
        bus.periph_enable = 8'hBF;
        cnt[6] = 10;
        drive_fifos();
        for (int k = 0; k < 10; k++) step();
        vectors++;
        if (grants_q.size() != 0) begin miscompares++; $display("FAIL mask_block: got %0d grants, need 0", grants_q.size()); end
        bus.periph_enable = 8'hFF;
        step();
        vectors++;
        if (bus.grant_id !== 3'd6 || bus.grant_active !== 1'b1) begin
            miscompares++;
            $display("FAIL mask_grant: got id %0d active %b, need 6 1", bus.grant_id, bus.grant_active);
        end
        step();
        step();
        bus.periph_enable = 8'hBF;
        #1;
        vectors++;
        if (bus.periph_rd_en !== 8'h40) begin miscompares++; $display("FAIL mask_last_pop: got %h, need 40", bus.periph_rd_en); end
        step();
        #1;
        vectors += 2;
        if (bus.grant_active !== 1'b0) begin miscompares++; $display("FAIL mask_exit: got %b, need 0", bus.grant_active); end
        if (cnt[6] != 7) begin miscompares++; $display("FAIL mask_words: got %0d left, need 7", cnt[6]); end
        for (int k = 0; k < 5; k++) step();
        vectors++;
        if (grants_q.size() != 1) begin miscompares++; $display("FAIL mask_regrant: got %0d grants, need 1", grants_q.size()); end
        bus.periph_enable = 8'hFF;
        drain();
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        bus.read_data = 1'b1;
        cnt[7] = 10;
        drive_fifos();
        step();
        vectors++;
        if (bus.grant_id !== 3'd7) begin miscompares++; $display("FAIL midrst_grant: got %0d, need 7", bus.grant_id); end
        step();
        step();
        step();
        rst = 1'b1;
        #1;
        vectors++;
        if (bus.periph_rd_en !== 8'h00) begin miscompares++; $display("FAIL midrst_pop: got %h, need 00", bus.periph_rd_en); end
        step();
        #1;
        vectors += 4;
        if (bus.grant_active !== 1'b0) begin miscompares++; $display("FAIL midrst_active: got %b, need 0", bus.grant_active); end
        if (bus.data_available !== 1'b0) begin miscompares++; $display("FAIL midrst_avail: got %b, need 0", bus.data_available); end
        if (bus.periph_rd_en !== 8'h00) begin miscompares++; $display("FAIL midrst_rd_en: got %h, need 00", bus.periph_rd_en); end
        if (bus.grant_id !== 3'd0) begin miscompares++; $display("FAIL midrst_id: got %0d, need 0", bus.grant_id); end
        rst = 1'b0;
        cnt[0] = 3;
        drive_fifos();
        step();
        vectors += 2;
        if (bus.grant_active !== 1'b1 || bus.grant_id !== 3'd0) begin
            miscompares++;
            $display("FAIL midrst_next: got id %0d active %b, need 0 1", bus.grant_id, bus.grant_active);
        end
        if (cnt[7] != 7) begin miscompares++; $display("FAIL midrst_words: got %0d left, need 7", cnt[7]); end
        drain();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, need completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.periph_ready  = 1'b1;
        bus.periph_enable = 8'hFF;
        bus.read_data     = 1'b0;
        for (int i = 0; i < N; i++) begin
            cnt[i] = 0;
            popped[i] = 0;
        end
        drive_fifos();
        test_reset();
        test_two_ports();
        test_burst_limit();
        test_all_busy();
        test_read_toggle();
        test_enable_mask();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/periph_tx_arbiter.md
# periph_tx_arbiter

Round-robin arbiter that shares the FT601 USB write path among up to `NUM_PERIPHS` peripheral TX FIFOs. It sits between the peripheral FWFT FIFOs and the FT601 controller. It drives the controller's `periph_data_available` / `read_periph_data` handshake and presents the granted FIFO's head word plus its peripheral ID. Bursts are bounded by `BURST_MAX` so one busy peripheral cannot starve the others.

## Interface
- `NUM_PERIPHS`, 8: number of requesters, 2..16.
- `DATA_WIDTH`, 32: word width.
- `BURST_MAX`, 16: max words popped per grant, ≥1.
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `periph_ready` in 1: peripheral FIFOs initialised; low blocks new grants.
- `periph_enable` in `NUM_PERIPHS`: per-port enable mask, sampled at arbitration.
- `periph_empty` in `NUM_PERIPHS`: FWFT empty flags.
- `periph_data` in `NUM_PERIPHS*DATA_WIDTH`: flattened head words; port i at `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `periph_rd_en` out `NUM_PERIPHS`: one-hot pop to the granted FIFO.
- `data_available` out 1: head word of granted FIFO valid (to controller `periph_data_available`).
- `read_data` in 1: controller pops current word (from controller `read_periph_data`).
- `data_out` out `DATA_WIDTH`: granted FIFO head word.
- `grant_id` out `$clog2(NUM_PERIPHS)`: registered ID of current or last grant.
- `grant_active` out 1: state is GRANT.

## Operation
- States: IDLE, GRANT.
- IDLE:
  - Request vector = `~periph_empty & periph_enable`.
  - If `periph_ready` and the vector is nonzero: pick the first set bit searching from `last_id+1` upward with wrap. Register `grant_id = last_id = pick`, clear `burst_cnt`, go to GRANT.
- GRANT:
  - `data_available = ~periph_empty[grant_id]`.
  - `data_out = periph_data[grant_id]` (combinational mux from the registered ID).
  - `periph_rd_en[grant_id] = read_data & data_available`; every other bit is 0.
  - Each pop increments `burst_cnt` (width `$clog2(BURST_MAX+1)`).
- GRANT → IDLE when any of these holds:
  - a pop occurs with `burst_cnt == BURST_MAX-1`;
  - `periph_empty[grant_id]` is high;
  - `periph_ready` is low;
  - `periph_enable[grant_id]` is low.
- `read_data` while `data_available` is low is ignored: no pop, no count.
- In IDLE, `data_available`, `periph_rd_en`, and `grant_active` are 0. `data_out` still muxes from `grant_id` but is don't-care.
- Mid-burst `periph_ready` fall: any pop in that same cycle completes; exit at the next edge.

## Timing
- Reset values:
  - state IDLE;
  - `grant_id` 0;
  - `last_id` `NUM_PERIPHS-1`, so port 0 has first priority;
  - `burst_cnt` 0;
  - all outputs 0.
- Reset mid-burst: the grant is dropped at that edge. No pop is issued in the reset cycle.
- Arbitration latency: request visible in IDLE at edge N → `grant_active` and `data_available` high after edge N+1.
- Pops are single-cycle. Back-to-back pops give one word per clock.
- One dead IDLE cycle between grants, always, including a re-grant to the same port.
- Full burst: exactly `BURST_MAX` pops. `data_available` is low in the cycle after the last pop.
- Empty with a pop in the same cycle: the pop is valid and the exit follows. FWFT guarantees `periph_empty` updates the cycle after the pop.
- Inputs are not registered. `data_available` and `periph_rd_en` are combinational from registered state and `periph_empty`.

## Structure
- Package `periph_arb_pkg`:
  - `arb_state_t` enum {IDLE, GRANT};
  - `PERIPH_ID_W` localparam function of `NUM_PERIPHS`;
  - default `BURST_MAX`.
- Sub-module `rr_picker`: purely combinational, parameterised. Takes request vector and `last_id`; returns `valid` and `pick_id`. Implemented as a double-width rotate-and-priority-encode.
- Top holds the FSM, counter, and data mux.

## Test plan
- Reset, then ports 2 and 5 non-empty, `read_data` held high → grant 2, then grant 5. Exactly one IDLE cycle between them, and `grant_id` sequence 2, 5.
- Port 3 holds 40 words, `BURST_MAX=16`, port 4 holds 1 word → pops 16 from 3, 1 from 4, 16 from 3, 8 from 3. `periph_rd_en` is never multi-hot.
- All 8 ports always non-empty for 200 cycles → grants cycle 0..7 in order. Each grant is exactly 16 words; no port receives two grants in a row.
- `read_data` toggled 1,0,1,0 with port 1 holding 4 words → 4 pops on the high cycles only. `data_out` matches the FIFO order; `burst_cnt` ends at 4 before exit.
- `periph_enable[6]=0` with port 6 non-empty → port 6 is never granted. Clearing `periph_enable[6]` mid-burst on port 6 returns to IDLE after at most one more pop.
- `rst` asserted mid-burst on port 7 → next cycle all outputs are 0 and `grant_id` is 0. With ports 0 and 7 both pending afterward, the first grant goes to 0.
